// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its prefetch queue.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instr} entries with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, prefetches into a small queue and hands {pc, instr} to decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            deq, enq;
    logic            q_empty, q_full;
    fetch_entry_t    head, wentry;

    assign deq = out_valid & out_ready;
    // A full queue may still accept when the head leaves in the same cycle.
    assign enq = !redirect_valid & (!q_full | deq);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        else if (enq)
            pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign wentry.pc    = pc_q;
    assign wentry.instr = imem_rd;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (enq),
        .pop_i   (deq & !redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    assign imem_addr = pc_q;
    assign out_valid = !q_empty;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;

    // Behavioural model: expected fetch PC and queue of fetched PCs.
    logic [31:0] pc_m;
    logic [31:0] q_m[$];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a < 32'd32) return 32'h100 + (a >> 2);
        return {a[31:2], 2'b11} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rd = instr_of(imem_addr);

    task automatic model_reset();
        q_m.delete();
        pc_m = RESET_PC;
    endtask

    // Applies one rising edge worth of the fetch rules to the model, using current inputs.
    task automatic model_edge();
        bit deq, can;
        logic [31:0] tmp;
        deq = (q_m.size() > 0) && out_ready;
        if (redirect_valid) begin
            q_m.delete();
            pc_m = {redirect_pc[31:2], 2'b00};
        end else begin
            can = (q_m.size() < DEPTH) || deq;
            if (deq) tmp = q_m.pop_front();
            if (can) begin
                q_m.push_back(pc_m);
                pc_m = pc_m + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", out_instr, NOP); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_empty: got %b want 0", out_valid); end
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); end
            checks++; if (out_instr !== 32'(32'h100 + i)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, 32'(32'h100 + i)); end
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'h0; exp_pcs[1] = 32'h4; exp_pcs[2] = 32'h8;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c >= 3) begin
                checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 8", c, imem_addr); end
                checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_head[%0d]: got %b/%h want 1/0", c, out_valid, out_pc); end
            end
            model_edge();
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pcs[k]) begin errors++; $display("FAIL stall_release[%0d]: got %b/%h want 1/%h", k, out_valid, out_pc, exp_pcs[k]); end
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic run_redirect(input logic [31:0] target, input logic [31:0] aligned, input string tag);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            #1; model_edge(); @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc = target;
        out_ready = 1'b1;
        #1;
        model_edge();
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_flush: got valid %b want 0", tag, out_valid); end
        checks++; if (imem_addr !== aligned) begin errors++; $display("FAIL %s_addr: got %h want %h", tag, imem_addr, aligned); end
        model_edge();
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== aligned) begin errors++; $display("FAIL %s_target: got %b/%h want 1/%h", tag, out_valid, out_pc, aligned); end
        checks++; if (out_instr !== instr_of(aligned)) begin errors++; $display("FAIL %s_instr: got %h want %h", tag, out_instr, instr_of(aligned)); end
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_redirect();
        run_redirect(32'h40, 32'h40, "redirect");
    endtask

    task automatic test_misaligned();
        run_redirect(32'h47, 32'h44, "misaligned");
    endtask

    task automatic test_wrap();
        run_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC, "wrap");
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %b/%h want 1/0", out_valid, out_pc); end
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1; model_edge(); @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0) begin errors++; $display("FAIL midreset_out: got %b/%h/%h want 0/%h/0", out_valid, out_instr, out_pc, NOP); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL midreset_addr: got %h want %h", imem_addr, RESET_PC); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        bit          ev;
        logic [31:0] ep, ei;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom();
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            #1;
            ev = (q_m.size() > 0);
            ep = 32'h0;
            ei = NOP;
            if (ev) begin
                ep = q_m[0];
                ei = instr_of(q_m[0]);
            end
            checks++;
            if (out_valid !== ev || out_pc !== ep || out_instr !== ei || imem_addr !== pc_m) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b pc=%h ins=%h addr=%h want v=%b pc=%h ins=%h addr=%h",
                         c, out_valid, out_pc, out_instr, imem_addr, ev, ep, ei, pc_m);
            end
            model_edge();
            @(negedge clk);
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_streaming();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
